// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the mem_responder slice: FSM encoding,
// default geometry/latency and the address-legality helper.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEF_DEPTH   = 256;
  localparam int unsigned DEF_LATENCY = 3;
  localparam int unsigned CNT_W       = 4;

  // Misaligned byte address or word index beyond the array.
  function automatic logic addr_bad(input logic [31:0] a, input int unsigned depth);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// DEPTH x 32 storage: synchronous write, registered read. Only the read
// register is cleared; the storage itself is never reset.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[idx] <= wdata;
  end

  // Holds the last loaded word until the next load.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)      rdata_q <= '0;
    else if (rd_en) rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed LATENCY from accept to ack.
// Optional address checking is enabled by defining MEM_ERR_CHECK_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_LD = (LATENCY > 1) ? LATENCY - 2 : 0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic             req_err;
  logic [AW-1:0]    req_idx;
  logic             enter_resp;
  logic             wr_en, rd_en;

  assign req_idx = addr[AW+1:2];

`ifdef MEM_ERR_CHECK_EN
  assign req_err = addr_bad(addr, DEPTH);
`else
  logic unused_addr_bits;
  assign req_err          = 1'b0;
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          idx_d   = req_idx;
          wdata_d = wdata;
          err_d   = req_err;
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(CNT_LD);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The _d copies describe the access in flight on the edge entering RESP,
  // which also covers LATENCY=1 where that edge is the accepting one.
  assign enter_resp = (state_d == RESP) && (state_q != RESP) && !clear;
  assign wr_en      = enter_resp && we_d && !err_d;
  assign rd_en      = enter_resp && !we_d && !err_d;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  mem_resp_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock (clock),
    .clear (clear),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .idx   (idx_d),
    .wdata (wdata_d),
    .rdata (rdata)
  );

  assign ack  = (state_q == RESP);
  assign busy = (state_q != IDLE);
  assign err  = ack && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: LATENCY=3 main instance plus a
// LATENCY=1 instance for single-cycle timing.
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;

`ifdef MEM_ERR_CHECK_EN
  localparam logic        ERR_EXP   = 1'b1;
  localparam logic [31:0] LD0_EXP   = 32'h11111111;
  localparam logic [31:0] LD10_EXP  = 32'hDEADBEEF;
`else
  localparam logic        ERR_EXP   = 1'b0;
  localparam logic [31:0] LD0_EXP   = 32'hA5A5A5A5;
  localparam logic [31:0] LD10_EXP  = 32'hBADBAD00;
`endif

  logic        clock = 1'b0;
  logic        clear, req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ack, busy, err;
  logic        b_req, b_we;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_ack, b_busy, b_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int txn   = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   ack_cyc[$];

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock(clock), .clear(clear), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .err(err)
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .clock(clock), .clear(clear), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .ack(b_ack), .rdata(b_rdata), .busy(b_busy), .err(b_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expectation.
  always @(negedge clock) begin
    exp_t e;
    if (ack === 1'b1) begin
      ack_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        txn++;
        $display("txn %0d: ack rdata=%h err=%0b (expect %h/%0b)", txn, rdata, err, e.rd, e.e);
        chk("ack_rdata", rdata, e.rd);
        chk("ack_err", {31'b0, err}, {31'b0, e.e});
      end
    end
  end

  // Issue one access from a negedge; returns at the negedge after ack drops.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_e);
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    sb.push_back('{exp_rd, exp_e});
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    n = 1;
    while (ack !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("ack_latency", n, LAT);
    @(negedge clock);
    chk("ack_one_cycle", {31'b0, ack}, 32'd0);
    chk("idle_after_ack", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int n;
    clear = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    #1;
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_l1_busy", {31'b0, b_busy}, 32'd0);
    repeat (3) @(negedge clock);
    clear = 1'b0;

    access(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    chk("store_keeps_rdata", rdata, 32'h0);
    access(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clock);
    chk("rdata_held", rdata, 32'hDEADBEEF);
    access(1'b1, 32'h20, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0);
    access(1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

    // Store dropped by clear one cycle after acceptance.
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    @(posedge clock);
    #1 clear = 1'b1;
    #1;
    chk("clr_ack", {31'b0, ack}, 32'd0);
    chk("clr_busy", {31'b0, busy}, 32'd0);
    chk("clr_err", {31'b0, err}, 32'd0);
    chk("clr_rdata", rdata, 32'd0);
    @(negedge clock);
    clear = 1'b0;
    repeat (6) @(negedge clock);
    access(1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

    // req held high for 10 edges: accepts every LAT+1 cycles.
    repeat (3) sb.push_back('{32'hDEADBEEF, 1'b0});
    n0 = ack_cyc.size();
    req = 1'b1; we = 1'b0; addr = 32'h10;
    repeat (10) @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    repeat (8) @(negedge clock);
    chk("b2b_ack_count", ack_cyc.size() - n0, 32'd3);
    if (ack_cyc.size() - n0 >= 3) begin
      chk("b2b_spacing_1", ack_cyc[n0+1] - ack_cyc[n0], LAT + 1);
      chk("b2b_spacing_2", ack_cyc[n0+2] - ack_cyc[n0+1], LAT + 1);
    end

    // Out-of-range and misaligned addresses.
    access(1'b1, 32'h0, 32'h11111111, 32'hDEADBEEF, 1'b0);
    access(1'b1, DEPTH * 4, 32'hA5A5A5A5, 32'hDEADBEEF, ERR_EXP);
    access(1'b0, 32'h0, 32'h0, LD0_EXP, 1'b0);
    access(1'b1, 32'h13, 32'hBADBAD00, LD0_EXP, ERR_EXP);
    access(1'b0, 32'h10, 32'h0, LD10_EXP, 1'b0);

    // LATENCY=1 instance: store then load with req held high.
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h8; b_wdata = 32'h0BADF00D;
    @(negedge clock);
    $display("l1 txn: store ack=%0b rdata=%h", b_ack, b_rdata);
    chk("l1_store_ack", {31'b0, b_ack}, 32'd1);
    chk("l1_store_busy", {31'b0, b_busy}, 32'd1);
    chk("l1_store_rdata", b_rdata, 32'd0);
    b_we = 1'b0;
    @(negedge clock);
    chk("l1_gap_ack", {31'b0, b_ack}, 32'd0);
    chk("l1_gap_busy", {31'b0, b_busy}, 32'd0);
    @(negedge clock);
    $display("l1 txn: load ack=%0b rdata=%h err=%0b", b_ack, b_rdata, b_err);
    chk("l1_load_ack", {31'b0, b_ack}, 32'd1);
    chk("l1_load_rdata", b_rdata, 32'h0BADF00D);
    chk("l1_load_err", {31'b0, b_err}, 32'd0);
    b_req = 1'b0;
    @(negedge clock);
    chk("l1_ack_drop", {31'b0, b_ack}, 32'd0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter: DEPTH, 256, number of 32-bit words stored.
REQ-002 SHALL have parameter: LATENCY, 3, cycles from request acceptance to ack (legal 1..15).
REQ-003 SHALL have port: clock  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: clear  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: req  input  1  access request from CPU pipeline.
REQ-006 SHALL have port: we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 SHALL have port: addr  input  32  byte address; word index = addr[log2(DEPTH)+1:2].
REQ-008 SHALL have port: wdata  input  32  store data; sampled with req.
REQ-009 SHALL have port: ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: rdata  output  32  load data, valid while ack high.
REQ-011 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port: err  output  1  error flag, valid while ack high.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 SHALL accept a request on a rising edge where req=1 and state=IDLE, capturing we, addr, wdata in that edge.
REQ-015 SHALL ignore req when state is WAIT or RESP; no queuing.
REQ-016 SHALL go IDLE->WAIT on acceptance when LATENCY>1, IDLE->RESP when LATENCY=1.
REQ-017 SHALL hold WAIT for LATENCY-1 cycles via a down-counter loaded on acceptance, then enter RESP.
REQ-018 SHALL assert ack for exactly one cycle in RESP, i.e. LATENCY cycles after the accepting edge, then return to IDLE.
REQ-019 SHALL commit a store to storage on the edge entering RESP; a load in the same position reads storage at that edge.
REQ-020 SHALL drive rdata with the loaded word during ack and hold the last value until the next load ack; store acks leave rdata unchanged.
REQ-021 SHALL sustain at most one access per LATENCY+1 cycles; req high continuously yields back-to-back accepts every LATENCY+1 cycles.
REQ-022 SHALL return the newly written value on a load that follows a store to the same address.

Reset
REQ-023 SHALL on clear=1 immediately force state=IDLE, counter=0, ack=0, busy=0, err=0, rdata=0.
REQ-024 SHALL drop any in-flight access on clear mid-operation; a pending store is not committed.
REQ-025 SHALL NOT alter storage contents on clear; contents are undefined until written.

Configuration
REQ-026 SHALL honour macro MEM_ERR_CHECK_EN.
REQ-027 With MEM_ERR_CHECK_EN defined: addr[1:0]!=0 or word index >= DEPTH sets err=1 during ack, store suppressed, rdata unchanged; timing unchanged.
REQ-028 Without MEM_ERR_CHECK_EN: addr[1:0] ignored, index wraps modulo DEPTH, err tied to 0.

Structure
REQ-029 SHALL place state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and default DEPTH/LATENCY constants in shared package mem_resp_pkg.
REQ-030 SHALL instantiate one sub-module mem_resp_array: DEPTH x 32 synchronous-write, indexed-read storage with write enable.

Verification
REQ-031 LATENCY=3: store req at edge 0, addr=0x10, wdata=0xDEADBEEF -> busy=1 edges 0..2, ack=1 only after edge 3, err=0.
REQ-032 Then load addr=0x10 -> ack 3 cycles after accept, rdata=0xDEADBEEF, held after ack drops.
REQ-033 req held high 10 cycles, LATENCY=3 -> exactly 3 acks, spaced 4 cycles apart; req during WAIT ignored.
REQ-034 Store addr=0x20 wdata=0x12345678, clear pulsed 1 cycle later -> ack never asserted, outputs 0 immediately; later load of 0x20 returns prior contents, not 0x12345678.
REQ-035 MEM_ERR_CHECK_EN, store addr=0x13 -> ack with err=1, storage at 0x10 unchanged; addr=DEPTH*4 -> err=1. Without macro, addr=DEPTH*4 aliases word 0.
REQ-036 LATENCY=1: load accepted at edge 0 -> ack after edge 1, next accept possible at edge 2.
